// File: rtl/bike_trail_if.sv
// bike_trail_if: groups the game-controller side and the trail-checker side
// of the light-bike tracker into one bundle.
//   master : game controller / bench. Drives frame_tick, game_start,
//            start_x/start_y/start_dir, dir_valid/dir_req and collide.
//            Observes head/segment/crash status.
//   slave  : bike_trail_tracker. Consumes the controls and drives
//            head_x/head_y, cur_dir, seg_startaddr/seg_w/seg_h,
//            seg_valid, seg_done and crashed.
interface bike_trail_if;
    logic        frame_tick;
    logic        game_start;
    logic [9:0]  start_x;
    logic [9:0]  start_y;
    logic [1:0]  start_dir;
    logic        dir_valid;
    logic [1:0]  dir_req;
    logic        collide;
    logic [9:0]  head_x;
    logic [9:0]  head_y;
    logic [1:0]  cur_dir;
    logic [18:0] seg_startaddr;
    logic [9:0]  seg_w;
    logic [9:0]  seg_h;
    logic        seg_valid;
    logic        seg_done;
    logic        crashed;

    modport master (
        output frame_tick, game_start, start_x, start_y, start_dir,
               dir_valid, dir_req, collide,
        input  head_x, head_y, cur_dir, seg_startaddr, seg_w, seg_h,
               seg_valid, seg_done, crashed
    );

    modport slave (
        input  frame_tick, game_start, start_x, start_y, start_dir,
               dir_valid, dir_req, collide,
        output head_x, head_y, cur_dir, seg_startaddr, seg_w, seg_h,
               seg_valid, seg_done, crashed
    );
endinterface

// File: rtl/bike_trail_tracker.sv
// bike_trail_tracker: moves one light bike and tracks the straight trail
// segment it is currently laying, as a rectangle (top-left pixel address,
// width, height) for the per-pixel trail checkers. Each turn pulses seg_done
// while seg_* still hold the closed segment so a segment store can latch it.
// Ports:
//   clock  : system clock, all state on the rising edge
//   resetn : asynchronous active-low reset
//   bus    : bike_trail_if.slave (controls in, head/segment/crash status out)
// Directions: 0=up 1=right 2=down 3=left.
module bike_trail_tracker #(
    parameter int TRAIL_W  = 14,
    parameter int STEP     = 2,
    parameter int MOVE_DIV = 2,
    parameter int SCR_W    = 640,
    parameter int SCR_H    = 480
) (
    input  logic         clock,
    input  logic         resetn,
    bike_trail_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CRASH = 2'd2;

    localparam int          CW     = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] XMAX   = 11'(SCR_W - TRAIL_W);
    localparam logic [10:0] YMAX   = 11'(SCR_H - TRAIL_W);
    localparam logic [9:0]  T_W    = 10'(TRAIL_W);

    logic [1:0]    state_q, state_d;
    logic [9:0]    hx_q, hx_d, hy_q, hy_d, ax_q, ax_d, ay_q, ay_d;
    logic [1:0]    dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_vld_q, pend_vld_d;
    logic [1:0]    pend_dir_q, pend_dir_d;
    // turn_q marks the cycle after seg_done: anchor/dir swap plus the step
    logic          turn_q, turn_d;
    logic [1:0]    turn_dir_q, turn_dir_d;
    logic          done_q, done_d;
    logic [18:0]   addr_q, addr_d;
    logic [9:0]    w_q, w_d, h_q, h_d;
    logic          sv_q, sv_d;

    // Candidate step position; a turn moves in the new direction.
    logic [1:0]  mv_dir;
    logic [10:0] nx, ny;
    logic        mv_ok;
    logic        tick_wrap;

    always_comb begin
        mv_dir = turn_q ? turn_dir_q : dir_q;
        nx     = {1'b0, hx_q};
        ny     = {1'b0, hy_q};
        mv_ok  = 1'b1;
        case (mv_dir)
            2'd0: if ({1'b0, hy_q} < STEP_W) mv_ok = 1'b0;
                  else ny = {1'b0, hy_q} - STEP_W;
            2'd1: begin
                nx = {1'b0, hx_q} + STEP_W;
                if (nx > XMAX) mv_ok = 1'b0;
            end
            2'd2: begin
                ny = {1'b0, hy_q} + STEP_W;
                if (ny > YMAX) mv_ok = 1'b0;
            end
            default: if ({1'b0, hx_q} < STEP_W) mv_ok = 1'b0;
                     else nx = {1'b0, hx_q} - STEP_W;
        endcase
    end

    assign tick_wrap = bus.frame_tick && (cnt_q == CW'(MOVE_DIV - 1));

    always_comb begin
        state_d    = state_q;
        hx_d       = hx_q;
        hy_d       = hy_q;
        ax_d       = ax_q;
        ay_d       = ay_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        pend_vld_d = pend_vld_q;
        pend_dir_d = pend_dir_q;
        turn_d     = turn_q;
        turn_dir_d = turn_dir_q;
        done_d     = 1'b0;
        if (bus.game_start) begin
            state_d    = S_RUN;
            hx_d       = bus.start_x;
            hy_d       = bus.start_y;
            ax_d       = bus.start_x;
            ay_d       = bus.start_y;
            dir_d      = bus.start_dir;
            cnt_d      = '0;
            pend_vld_d = 1'b0;
            turn_d     = 1'b0;
        end else if (state_q == S_RUN) begin
            if (bus.frame_tick) cnt_d = tick_wrap ? '0 : cnt_q + CW'(1);
            if (bus.collide) begin
                state_d = S_CRASH;
                turn_d  = 1'b0;
            end else if (turn_q) begin
                turn_d = 1'b0;
                dir_d  = turn_dir_q;
                ax_d   = hx_q;
                ay_d   = hy_q;
                if (mv_ok) begin
                    hx_d = nx[9:0];
                    hy_d = ny[9:0];
                end else begin
                    state_d = S_CRASH;
                end
            end else if (tick_wrap) begin
                if (pend_vld_q) begin
                    // Close the segment first; the step happens next cycle.
                    done_d     = 1'b1;
                    turn_d     = 1'b1;
                    turn_dir_d = pend_dir_q;
                    pend_vld_d = 1'b0;
                end else if (mv_ok) begin
                    hx_d = nx[9:0];
                    hy_d = ny[9:0];
                end else begin
                    state_d = S_CRASH;
                end
            end
            // Evaluated after consumption so a same-cycle request survives.
            if (bus.dir_valid && bus.dir_req != dir_q && bus.dir_req != (dir_q ^ 2'd2)) begin
                pend_vld_d = 1'b1;
                pend_dir_d = bus.dir_req;
            end
        end
    end

    // Segment rectangle, refreshed only while running so CRASH freezes it.
    logic [9:0] sx, sy;
    always_comb begin
        sx     = ax_q;
        sy     = ay_q;
        w_d    = w_q;
        h_d    = h_q;
        addr_d = addr_q;
        sv_d   = sv_q;
        if (state_q == S_RUN) begin
            sv_d = 1'b1;
            case (dir_q)
                2'd0: begin sy = hy_q; w_d = T_W;               h_d = ay_q - hy_q + T_W; end
                2'd1: begin            w_d = hx_q - ax_q + T_W; h_d = T_W;               end
                2'd2: begin            w_d = T_W;               h_d = hy_q - ay_q + T_W; end
                default: begin sx = hx_q; w_d = ax_q - hx_q + T_W; h_d = T_W;           end
            endcase
            // y*640 = y*512 + y*128
            addr_d = ({9'd0, sy} << 9) + ({9'd0, sy} << 7) + {9'd0, sx};
        end else if (state_q == S_IDLE) begin
            sv_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            hx_q       <= '0;
            hy_q       <= '0;
            ax_q       <= '0;
            ay_q       <= '0;
            dir_q      <= 2'd1;
            cnt_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_dir_q <= '0;
            turn_q     <= 1'b0;
            turn_dir_q <= '0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            w_q        <= '0;
            h_q        <= '0;
            sv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            hx_q       <= hx_d;
            hy_q       <= hy_d;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_dir_q <= pend_dir_d;
            turn_q     <= turn_d;
            turn_dir_q <= turn_dir_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            w_q        <= w_d;
            h_q        <= h_d;
            sv_q       <= sv_d;
        end
    end

    assign bus.head_x        = hx_q;
    assign bus.head_y        = hy_q;
    assign bus.cur_dir       = dir_q;
    assign bus.seg_startaddr = addr_q;
    assign bus.seg_w         = w_q;
    assign bus.seg_h         = h_q;
    assign bus.seg_valid     = sv_q;
    assign bus.seg_done      = done_q;
    assign bus.crashed       = (state_q == S_CRASH);
endmodule

// File: tb/tb_bike_trail_tracker.sv
// Bench for bike_trail_tracker: directed scenarios, a game-level model of the
// bike (positions as integers, the trail as the bounding box of the anchor and
// head squares) compared against the DUT every cycle, plus literal checks.
module tb_bike_trail_tracker;
    localparam int T = 14, ST = 2, DIV = 2, SW = 640, SH = 480;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    bike_trail_if bus();

    bike_trail_tracker #(.TRAIL_W(T), .STEP(ST), .MOVE_DIV(DIV), .SCR_W(SW), .SCR_H(SH))
        dut (.clock(clock), .resetn(resetn), .bus(bus));

    always #5 clock = ~clock;

    int n_cmp = 0, n_err = 0;
    bit cmp_en = 1'b0;
    int done_cnt = 0, done_w = 0, done_h = 0, done_addr = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // mode: 0 idle, 1 run, 2 crash; m_pend/m_turn = -1 when empty
    int m_mode, m_hx, m_hy, m_ax, m_ay, m_dir, m_cnt, m_pend, m_turn, m_od, m_pm;
    int e_addr, e_w, e_h, e_valid, e_done;
    bit m_wrap;
    int dxs[4] = '{0, 1, 0, -1};
    int dys[4] = '{-1, 0, 1, 0};

    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
    function automatic int iabs(input int a); return (a < 0) ? -a : a; endfunction

    task automatic m_step(input int d);
        int nx, ny;
        nx = m_hx + dxs[d] * ST;
        ny = m_hy + dys[d] * ST;
        if (nx < 0 || nx > SW - T || ny < 0 || ny > SH - T) m_mode = 2;
        else begin
            m_hx = nx;
            m_hy = ny;
        end
    endtask

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_mode = 0; m_hx = 0; m_hy = 0; m_ax = 0; m_ay = 0; m_dir = 1;
            m_cnt = 0; m_pend = -1; m_turn = -1;
            e_addr = 0; e_w = 0; e_h = 0; e_valid = 0; e_done = 0;
        end else begin
            m_pm = m_mode;
            // published rectangle lags head/anchor by one cycle
            if (m_pm == 1) begin
                e_addr  = imin(m_ay, m_hy) * SW + imin(m_ax, m_hx);
                e_w     = iabs(m_hx - m_ax) + T;
                e_h     = iabs(m_hy - m_ay) + T;
                e_valid = 1;
            end else if (m_pm == 0) e_valid = 0;
            e_done = 0;
            if (bus.game_start) begin
                m_mode = 1; m_hx = bus.start_x; m_hy = bus.start_y;
                m_ax = m_hx; m_ay = m_hy; m_dir = bus.start_dir;
                m_cnt = 0; m_pend = -1; m_turn = -1;
            end else if (m_pm == 1) begin
                m_od = m_dir;
                m_wrap = 1'b0;
                if (bus.frame_tick) begin
                    m_cnt  = (m_cnt + 1) % DIV;
                    m_wrap = (m_cnt == 0);
                end
                if (bus.collide) begin
                    m_mode = 2;
                    m_turn = -1;
                end else if (m_turn >= 0) begin
                    m_dir = m_turn; m_turn = -1;
                    m_ax = m_hx; m_ay = m_hy;
                    m_step(m_dir);
                end else if (m_wrap) begin
                    if (m_pend >= 0) begin
                        e_done = 1; m_turn = m_pend; m_pend = -1;
                    end else m_step(m_dir);
                end
                if (bus.dir_valid && int'(bus.dir_req) != m_od && int'(bus.dir_req) != (m_od ^ 2))
                    m_pend = bus.dir_req;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("head_x", bus.head_x, m_hx);
            chk("head_y", bus.head_y, m_hy);
            chk("cur_dir", bus.cur_dir, m_dir);
            chk("crashed", bus.crashed, (m_mode == 2) ? 1 : 0);
            chk("seg_valid", bus.seg_valid, e_valid);
            chk("seg_done", bus.seg_done, e_done);
            chk("seg_startaddr", bus.seg_startaddr, e_addr);
            chk("seg_w", bus.seg_w, e_w);
            chk("seg_h", bus.seg_h, e_h);
            if (bus.seg_done) begin
                done_cnt++;
                done_w = bus.seg_w;
                done_h = bus.seg_h;
                done_addr = bus.seg_startaddr;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clock) bus.frame_tick = 1'b1;
            @(negedge clock) bus.frame_tick = 1'b0;
            idle(2);
        end
    endtask

    task automatic start(input int x, input int y, input int d);
        @(negedge clock);
        bus.game_start = 1'b1;
        bus.start_x = 10'(x); bus.start_y = 10'(y); bus.start_dir = 2'(d);
        @(negedge clock) bus.game_start = 1'b0;
    endtask

    task automatic steer(input int d);
        @(negedge clock);
        bus.dir_valid = 1'b1;
        bus.dir_req = 2'(d);
        @(negedge clock) bus.dir_valid = 1'b0;
    endtask

    int d0;

    initial begin
        bus.frame_tick = 0; bus.game_start = 0; bus.start_x = 0; bus.start_y = 0;
        bus.start_dir = 0; bus.dir_valid = 0; bus.dir_req = 0; bus.collide = 0;
        idle(3);
        cmp_en = 1'b1;
        // reset state
        chk("rst head_x", bus.head_x, 0);
        chk("rst cur_dir", bus.cur_dir, 1);
        chk("rst seg_valid", bus.seg_valid, 0);
        chk("rst crashed", bus.crashed, 0);
        chk("rst seg_startaddr", bus.seg_startaddr, 0);
        @(negedge clock) resetn = 1'b1;
        tick_n(2);  // IDLE: nothing moves
        chk("idle head_x", bus.head_x, 0);

        // 1: run right from (100,200)
        start(100, 200, 1);
        tick_n(4);
        idle(1);
        chk("t1 head_x", bus.head_x, 104);
        chk("t1 seg_startaddr", bus.seg_startaddr, 128100);
        chk("t1 seg_w", bus.seg_w, 18);
        chk("t1 seg_h", bus.seg_h, 14);
        chk("t1 seg_valid", bus.seg_valid, 1);

        // 2: turn down
        d0 = done_cnt;
        steer(2);
        tick_n(2);
        idle(1);
        chk("t2 seg_done count", done_cnt, d0 + 1);
        chk("t2 closed w", done_w, 18);
        chk("t2 closed h", done_h, 14);
        chk("t2 closed addr", done_addr, 128100);
        chk("t2 head_y", bus.head_y, 202);
        chk("t2 cur_dir", bus.cur_dir, 2);
        chk("t2 seg_h", bus.seg_h, 16);
        chk("t2 seg_w", bus.seg_w, 14);
        chk("t2 seg_startaddr", bus.seg_startaddr, 200 * 640 + 104);

        // 3: reverse dropped; newest pending request wins
        start(50, 50, 1);
        d0 = done_cnt;
        steer(3);
        tick_n(2);
        chk("t3 reverse no seg_done", done_cnt, d0);
        chk("t3 head_x", bus.head_x, 52);
        steer(0);
        steer(2);
        tick_n(2);
        idle(1);
        chk("t3 seg_done count", done_cnt, d0 + 1);
        chk("t3 cur_dir", bus.cur_dir, 2);
        chk("t3 head_y", bus.head_y, 52);
        chk("t3 seg_startaddr", bus.seg_startaddr, 32052);
        chk("t3 seg_h", bus.seg_h, 16);

        // 4: right wall; 626 is the last legal column, 628 crashes
        start(624, 0, 1);
        tick_n(2);
        chk("t4 head_x edge", bus.head_x, 626);
        chk("t4 not crashed", bus.crashed, 0);
        tick_n(2);
        chk("t4 crashed", bus.crashed, 1);
        chk("t4 head_x held", bus.head_x, 626);
        steer(2);
        tick_n(4);
        chk("t4 frozen head_x", bus.head_x, 626);
        chk("t4 frozen dir", bus.cur_dir, 1);
        chk("t4 frozen seg_w", bus.seg_w, 16);

        // 4b: top wall underflow
        start(100, 0, 0);
        tick_n(2);
        chk("t4b crashed", bus.crashed, 1);
        chk("t4b head_y", bus.head_y, 0);

        // 5: collide on the move-step cycle wins
        start(300, 300, 0);
        tick_n(1);
        @(negedge clock);
        bus.collide = 1'b1; bus.frame_tick = 1'b1;
        @(negedge clock);
        bus.collide = 1'b0; bus.frame_tick = 1'b0;
        idle(1);
        chk("t5 crashed", bus.crashed, 1);
        chk("t5 head_y", bus.head_y, 300);
        start(10, 20, 2);
        idle(1);
        chk("t5 restart crashed", bus.crashed, 0);
        chk("t5 restart head_x", bus.head_x, 10);
        chk("t5 restart head_y", bus.head_y, 20);

        // 6: async reset mid-run
        tick_n(2);
        chk("t6 head_y before", bus.head_y, 22);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("t6 async head_x", bus.head_x, 0);
        chk("t6 async head_y", bus.head_y, 0);
        chk("t6 async cur_dir", bus.cur_dir, 1);
        chk("t6 async seg_valid", bus.seg_valid, 0);
        chk("t6 async seg_startaddr", bus.seg_startaddr, 0);
        @(negedge clock) resetn = 1'b1;
        tick_n(4);
        chk("t6 idle head_y", bus.head_y, 0);
        chk("t6 idle seg_valid", bus.seg_valid, 0);
        start(200, 100, 3);
        tick_n(2);
        idle(1);
        chk("t6 left head_x", bus.head_x, 198);
        chk("t6 left seg_startaddr", bus.seg_startaddr, 64198);
        chk("t6 left seg_w", bus.seg_w, 16);

        idle(2);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
